regfile: RTL and testbench
==========================

# regfile

Architectural register file with rename status for the Tomasulo core: 32 x 32-bit integer registers, each carrying a busy bit and the ROB tag (Q) of its newest in-flight producer. Sits between issue and the ROB. Issue reads operand state (value or pending tag) and renames the destination. The ROB commit port writes retired values back and releases the rename. A flush on misprediction drops all renames.

## Interface
Parameters:
- REG_ADDR_WIDTH, 5, register index width (32 registers)
- Q_WIDTH, 5, ROB tag width

Ports (one clock; reset is asynchronous and active-high):
- clk_in  input  1  clock, rising edge
- rst_in  input  1  asynchronous active-high reset
- rdy_in  input  1  global enable; low freezes all state
- issue_valid  input  1  rename destination this cycle
- issue_rd  input  REG_ADDR_WIDTH  destination register of issuing instruction
- issue_Q  input  Q_WIDTH  ROB tag (ROB_tail) allocated to that instruction
- rs1_addr, rs2_addr  input  REG_ADDR_WIDTH  operand register indices
- rs1_busy, rs2_busy  output  1  operand pending on an in-flight producer
- rs1_Q, rs2_Q  output  Q_WIDTH  producer tag, valid when busy
- rs1_V, rs2_V  output  32  operand value, valid when not busy
- commit_valid  input  1  ROB retires an instruction with a register destination
- commit_rd  input  REG_ADDR_WIDTH  retired destination
- commit_Q  input  Q_WIDTH  ROB tag of retired entry (Commit_Q)
- commit_V  input  32  retired value (Commit_V)
- flush  input  1  misprediction; clear all renames

## Operation
- State: reg[0..31] 32 bit, busy[0..31], Q[0..31] Q_WIDTH bit.
- x0: never written, never busy. Reads return busy=0, Q=0, V=0 regardless of issue/commit traffic.
- Read ports: purely combinational. Both ports are identical.
- Read bypass applies when all hold: rdy_in, commit_valid, commit_rd==rsX_addr!=0, busy[rsX], Q[rsX]==commit_Q. Output is then busy=0, Q=0, V=commit_V.
- Otherwise the read returns busy[rsX], Q[rsX] (0 when not busy), reg[rsX].
- Reads see pre-issue state: an instruction with rd==rs1 reads the old producer, not its own tag.
- Commit (rdy_in && commit_valid && commit_rd!=0):
  - reg[commit_rd] <= commit_V.
  - busy[commit_rd] cleared only if Q[commit_rd]==commit_Q, i.e. no younger rename exists.
- Issue (rdy_in && issue_valid && issue_rd!=0 && !flush): busy[issue_rd] <= 1, Q[issue_rd] <= issue_Q.
- Same register, same cycle issue and commit: issue wins on busy/Q; commit value is still written.
- Flush (rdy_in && flush): all busy <= 0, Q <= 0. Issue this cycle is ignored. Commit this cycle still writes its value.
- rdy_in low: no register, busy or Q update. Read outputs stay valid, with bypass disabled.

## Timing
- Read latency 0 (combinational from rsX_addr and commit inputs).
- Issue/commit/flush take effect at the next rising clk_in. They are visible to reads in the following cycle.
- Reset (async, any time, including mid-flush or mid-commit): reg=0, busy=0, Q=0 immediately. All read outputs are 0 while rst_in is high and after release until written.
- No handshake; every port is accepted in the cycle it is asserted with rdy_in high. There is no backpressure.

## Structure
- Shared package: REG_ADDR_WIDTH, Q_WIDTH, NUM_REGS=32, ZERO_REG=0. The ROB, issue unit and reservation stations use the same package.
- Sub-module regfile_read_port: one read port including the commit bypass. Instantiated twice.
- Update logic is a single always block with asynchronous reset. Priority: reset > rdy_in gate > flush > issue > commit-release. The commit value write is independent of this priority.

## Test plan
- Reset then read x5, x31 -> busy=0, Q=0, V=0 on both ports.
- Issue rd=3, Q=7. Next cycle read x3 -> busy=1, Q=7. Commit rd=3, Q=7, V=0xDEADBEEF -> same-cycle read gives busy=0, V=0xDEADBEEF; next cycle same from state.
- Issue rd=4 Q=2, then issue rd=4 Q=9, then commit rd=4 Q=2 V=0x11 -> reg[4]=0x11, x4 still busy with Q=9. Commit Q=9 V=0x22 clears busy, V=0x22.
- Same cycle: issue rd=6 Q=12 and commit rd=6 (matching old Q=5) V=0x55 -> x6 busy with Q=12, reg[6]=0x55.
- Rename x1, x2, x10. Assert flush together with issue rd=8 Q=3 -> all busy=0 next cycle, x8 not renamed.
- Issue rd=0 Q=1, commit rd=0 V=0xFF -> x0 reads 0, not busy. With rdy_in=0, issue rd=5 -> x5 unchanged.

Source files
------------

// File: rtl/regfile_pkg.sv
//----------------------------------------------------------------------------
// Module   : regfile_pkg
// Purpose  : Shared widths and constants for the register file. The ROB,
//            issue unit and reservation stations use the same package.
// Revision : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

package regfile_pkg;

    localparam int REG_ADDR_WIDTH = 5;   // register index width
    localparam int Q_WIDTH        = 5;   // ROB tag width
    localparam int NUM_REGS       = 32;  // architectural integer registers
    localparam int ZERO_REG       = 0;   // hard-wired zero register index
    localparam int DATA_WIDTH     = 32;  // register value width

endpackage : regfile_pkg

`default_nettype wire

// File: rtl/regfile_read_port.sv
//----------------------------------------------------------------------------
// Module   : regfile_read_port
// Purpose  : One combinational operand read port of the register file,
//            including the same-cycle commit bypass.
// Ports    : i_rdy, i_commit_*   - commit port, used only for the bypass
//            i_addr              - operand register index
//            i_busy, i_q, i_val  - full register file state
//            o_busy, o_q, o_v    - operand state (tag when busy, else value)
// Revision : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int ADDR_W = REG_ADDR_WIDTH,
    parameter int Q_W    = Q_WIDTH
) (
    input  logic                                 i_rdy,
    input  logic                                 i_commit_valid,
    input  logic [ADDR_W-1:0]                    i_commit_rd,
    input  logic [Q_W-1:0]                       i_commit_q,
    input  logic [DATA_WIDTH-1:0]                i_commit_v,
    input  logic [ADDR_W-1:0]                    i_addr,
    input  logic [NUM_REGS-1:0]                  i_busy,
    input  logic [NUM_REGS-1:0][Q_W-1:0]         i_q,
    input  logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  i_val,
    output logic                                 o_busy,
    output logic [Q_W-1:0]                       o_q,
    output logic [DATA_WIDTH-1:0]                o_v
);

    logic w_is_zero;
    logic w_bypass;

    assign w_is_zero = (i_addr == ADDR_W'(ZERO_REG));

    // The retiring producer is exactly the one this operand waits on, so the
    // committed value is handed over directly instead of a stale tag.
    assign w_bypass = i_rdy && i_commit_valid && !w_is_zero &&
                      (i_commit_rd == i_addr) && i_busy[i_addr] &&
                      (i_q[i_addr] == i_commit_q);

    always_comb begin
        o_busy = 1'b0;
        o_q    = '0;
        o_v    = '0;
        if (w_is_zero) begin
            o_busy = 1'b0;
        end else if (w_bypass) begin
            o_v    = i_commit_v;
        end else begin
            o_busy = i_busy[i_addr];
            // A stale tag may linger after release; only expose it while busy.
            o_q    = i_busy[i_addr] ? i_q[i_addr] : '0;
            o_v    = i_val[i_addr];
        end
    end

endmodule : regfile_read_port

`default_nettype wire

// File: rtl/regfile.sv
//----------------------------------------------------------------------------
// Module   : regfile
// Purpose  : Architectural register file with rename status (busy bit and
//            newest producer ROB tag per register) for the Tomasulo core.
// Ports    : clk_in, rst_in (async, active-high), rdy_in (global enable)
//            issue_*   - rename destination of the issuing instruction
//            rs1_*/rs2_* - two combinational operand read ports
//            commit_*  - ROB retirement write-back and rename release
//            flush     - drop all renames on misprediction
// Revision : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module regfile #(
    parameter int REG_ADDR_WIDTH = regfile_pkg::REG_ADDR_WIDTH,
    parameter int Q_WIDTH        = regfile_pkg::Q_WIDTH
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      rdy_in,
    input  logic                      issue_valid,
    input  logic [REG_ADDR_WIDTH-1:0] issue_rd,
    input  logic [Q_WIDTH-1:0]        issue_Q,
    input  logic [REG_ADDR_WIDTH-1:0] rs1_addr,
    input  logic [REG_ADDR_WIDTH-1:0] rs2_addr,
    output logic                      rs1_busy,
    output logic                      rs2_busy,
    output logic [Q_WIDTH-1:0]        rs1_Q,
    output logic [Q_WIDTH-1:0]        rs2_Q,
    output logic [31:0]               rs1_V,
    output logic [31:0]               rs2_V,
    input  logic                      commit_valid,
    input  logic [REG_ADDR_WIDTH-1:0] commit_rd,
    input  logic [Q_WIDTH-1:0]        commit_Q,
    input  logic [31:0]               commit_V,
    input  logic                      flush
);

    import regfile_pkg::*;

    logic [NUM_REGS-1:0]                 r_busy;
    logic [NUM_REGS-1:0][Q_WIDTH-1:0]    r_q;
    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] r_val;

    logic w_commit_en;
    logic w_commit_release;
    logic w_issue_en;

    // x0 is never a target, so its entry keeps its reset value forever.
    assign w_commit_en      = commit_valid && (commit_rd != REG_ADDR_WIDTH'(ZERO_REG));
    assign w_issue_en       = issue_valid  && (issue_rd  != REG_ADDR_WIDTH'(ZERO_REG));
    // Only the newest producer may release the rename; an older commit still
    // writes its value but leaves the younger rename in place.
    assign w_commit_release = w_commit_en && (r_q[commit_rd] == commit_Q);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_busy <= '0;
            r_q    <= '0;
            r_val  <= '0;
        end else if (rdy_in) begin
            // The retired value is architectural state and is written even
            // when the rename itself is flushed or overtaken.
            if (w_commit_en) begin
                r_val[commit_rd] <= commit_V;
            end
            if (flush) begin
                r_busy <= '0;
                r_q    <= '0;
            end else begin
                if (w_commit_release) begin
                    r_busy[commit_rd] <= 1'b0;
                end
                // Placed after the release so a same-register issue wins.
                if (w_issue_en) begin
                    r_busy[issue_rd] <= 1'b1;
                    r_q[issue_rd]    <= issue_Q;
                end
            end
        end
    end

    regfile_read_port #(
        .ADDR_W (REG_ADDR_WIDTH),
        .Q_W    (Q_WIDTH)
    ) u_rs1_port (
        .i_rdy          (rdy_in),
        .i_commit_valid (commit_valid),
        .i_commit_rd    (commit_rd),
        .i_commit_q     (commit_Q),
        .i_commit_v     (commit_V),
        .i_addr         (rs1_addr),
        .i_busy         (r_busy),
        .i_q            (r_q),
        .i_val          (r_val),
        .o_busy         (rs1_busy),
        .o_q            (rs1_Q),
        .o_v            (rs1_V)
    );

    regfile_read_port #(
        .ADDR_W (REG_ADDR_WIDTH),
        .Q_W    (Q_WIDTH)
    ) u_rs2_port (
        .i_rdy          (rdy_in),
        .i_commit_valid (commit_valid),
        .i_commit_rd    (commit_rd),
        .i_commit_q     (commit_Q),
        .i_commit_v     (commit_V),
        .i_addr         (rs2_addr),
        .i_busy         (r_busy),
        .i_q            (r_q),
        .i_val          (r_val),
        .o_busy         (rs2_busy),
        .o_q            (rs2_Q),
        .o_v            (rs2_V)
    );

endmodule : regfile

`default_nettype wire

// File: tb/tb_regfile.sv
//----------------------------------------------------------------------------
// Module   : tb_regfile
// Purpose  : Self-checking bench for regfile: directed vector table,
//            randomized traffic against a reference model, async reset.
// Revision : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module tb_regfile;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [4:0]  issue_Q;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        rs1_busy;
    logic        rs2_busy;
    logic [4:0]  rs1_Q;
    logic [4:0]  rs2_Q;
    logic [31:0] rs1_V;
    logic [31:0] rs2_V;
    logic        commit_valid;
    logic [4:0]  commit_rd;
    logic [4:0]  commit_Q;
    logic [31:0] commit_V;
    logic        flush;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk_in = ~clk_in;

    regfile dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .rdy_in       (rdy_in),
        .issue_valid  (issue_valid),
        .issue_rd     (issue_rd),
        .issue_Q      (issue_Q),
        .rs1_addr     (rs1_addr),
        .rs2_addr     (rs2_addr),
        .rs1_busy     (rs1_busy),
        .rs2_busy     (rs2_busy),
        .rs1_Q        (rs1_Q),
        .rs2_Q        (rs2_Q),
        .rs1_V        (rs1_V),
        .rs2_V        (rs2_V),
        .commit_valid (commit_valid),
        .commit_rd    (commit_rd),
        .commit_Q     (commit_Q),
        .commit_V     (commit_V),
        .flush        (flush)
    );

    typedef struct {
        logic        rdy;
        logic        iv;
        logic [4:0]  ird;
        logic [4:0]  iq;
        logic        cv;
        logic [4:0]  crd;
        logic [4:0]  cq;
        logic [31:0] cval;
        logic        fl;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic        eb1;
        logic [4:0]  eq1;
        logic [31:0] ev1;
        logic        eb2;
        logic [4:0]  eq2;
        logic [31:0] ev2;
    } vec_t;

    vec_t vecs[$];

    // Reference model: architectural values, rename busy flags and tags.
    logic [31:0] m_val  [32];
    logic        m_busy [32];
    logic [4:0]  m_q    [32];

    function automatic void m_clear(input logic clear_vals);
        for (int i = 0; i < 32; i++) begin
            if (clear_vals) m_val[i] = 32'h0;
            m_busy[i] = 1'b0;
            m_q[i]    = 5'h0;
        end
    endfunction

    function automatic void m_read(input logic [4:0] a, output logic b,
                                   output logic [4:0] q, output logic [31:0] v);
        b = 1'b0; q = 5'h0; v = 32'h0;
        if (a == 5'd0) begin
            b = 1'b0;
        end else if (rdy_in && commit_valid && commit_rd == a && m_busy[a] && m_q[a] == commit_Q) begin
            v = commit_V;
        end else begin
            b = m_busy[a];
            q = m_busy[a] ? m_q[a] : 5'h0;
            v = m_val[a];
        end
    endfunction

    function automatic void m_clock();
        if (!rdy_in) return;
        if (commit_valid && commit_rd != 5'd0) m_val[commit_rd] = commit_V;
        if (flush) begin
            m_clear(1'b0);
        end else begin
            if (commit_valid && commit_rd != 5'd0 && m_q[commit_rd] == commit_Q)
                m_busy[commit_rd] = 1'b0;
            if (issue_valid && issue_rd != 5'd0) begin
                m_busy[issue_rd] = 1'b1;
                m_q[issue_rd]    = issue_Q;
            end
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_ports(input string tag,
                             input logic eb1, input logic [4:0] eq1, input logic [31:0] ev1,
                             input logic eb2, input logic [4:0] eq2, input logic [31:0] ev2);
        chk({tag, ".rs1_busy"}, {31'h0, rs1_busy}, {31'h0, eb1});
        chk({tag, ".rs1_Q"},    {27'h0, rs1_Q},    {27'h0, eq1});
        chk({tag, ".rs1_V"},    rs1_V,             ev1);
        chk({tag, ".rs2_busy"}, {31'h0, rs2_busy}, {31'h0, eb2});
        chk({tag, ".rs2_Q"},    {27'h0, rs2_Q},    {27'h0, eq2});
        chk({tag, ".rs2_V"},    rs2_V,             ev2);
    endtask

    task automatic drive(input logic rdy, input logic iv, input logic [4:0] ird, input logic [4:0] iq,
                         input logic cv, input logic [4:0] crd, input logic [4:0] cq,
                         input logic [31:0] cval, input logic fl, input logic [4:0] a1, input logic [4:0] a2);
        rdy_in = rdy; issue_valid = iv; issue_rd = ird; issue_Q = iq;
        commit_valid = cv; commit_rd = crd; commit_Q = cq; commit_V = cval;
        flush = fl; rs1_addr = a1; rs2_addr = a2;
    endtask

    // Directed vector: inputs, then expected same-cycle read results.
    function automatic void add(input logic rdy, input logic iv, input logic [4:0] ird, input logic [4:0] iq,
                                input logic cv, input logic [4:0] crd, input logic [4:0] cq,
                                input logic [31:0] cval, input logic fl, input logic [4:0] a1, input logic [4:0] a2,
                                input logic eb1, input logic [4:0] eq1, input logic [31:0] ev1,
                                input logic eb2, input logic [4:0] eq2, input logic [31:0] ev2);
        vec_t v;
        v.rdy = rdy; v.iv = iv; v.ird = ird; v.iq = iq; v.cv = cv; v.crd = crd; v.cq = cq;
        v.cval = cval; v.fl = fl; v.a1 = a1; v.a2 = a2;
        v.eb1 = eb1; v.eq1 = eq1; v.ev1 = ev1; v.eb2 = eb2; v.eq2 = eq2; v.ev2 = ev2;
        vecs.push_back(v);
    endfunction

    task automatic random_cycles(input int n);
        logic b1, b2;
        logic [4:0] q1, q2;
        logic [31:0] v1, v2;
        logic [4:0] r;
        for (int k = 0; k < n; k++) begin
            r = 5'($urandom_range(1, 7));
            drive(($urandom_range(0, 9) != 0), 1'($urandom), 5'($urandom_range(0, 7)), 5'($urandom),
                  1'($urandom), 5'($urandom_range(0, 7)), 5'($urandom), $urandom,
                  ($urandom_range(0, 19) == 0),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)));
            // Bias half the commits to target a live rename so release and bypass fire.
            if ($urandom_range(0, 1) == 1 && m_busy[r]) begin
                commit_rd = r;
                commit_Q  = m_q[r];
                if ($urandom_range(0, 1) == 1) rs1_addr = r;
            end
            @(negedge clk_in);
            m_read(rs1_addr, b1, q1, v1);
            m_read(rs2_addr, b2, q2, v2);
            chk_ports("random", b1, q1, v1, b2, q2, v2);
            @(posedge clk_in);
            m_clock();
            #1;
        end
    endtask

    initial begin
        m_clear(1'b1);
        rst_in = 1'b1;
        drive(1'b1, 1'b1, 5'd5, 5'd3, 1'b1, 5'd5, 5'd0, 32'hAAAA_5555, 1'b0, 5'd5, 5'd31);
        #12;
        chk_ports("in_reset", 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        @(negedge clk_in);
        drive(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0, 32'h0, 1'b0, 5'd5, 5'd31);
        rst_in = 1'b0;
        @(posedge clk_in);
        #1;

        //   rdy iv ird    iq     cv crd   cq     cval          fl a1     a2      eb1 eq1    ev1           eb2 eq2    ev2
        add(1, 0, 5'd0,  5'd0,  0, 5'd0, 5'd0,  32'h0,        0, 5'd5,  5'd31,  0, 5'd0,  32'h0,        0, 5'd0,  32'h0);
        add(1, 1, 5'd3,  5'd7,  0, 5'd0, 5'd0,  32'h0,        0, 5'd3,  5'd0,   0, 5'd0,  32'h0,        0, 5'd0,  32'h0);
        add(1, 0, 5'd0,  5'd0,  0, 5'd0, 5'd0,  32'h0,        0, 5'd3,  5'd3,   1, 5'd7,  32'h0,        1, 5'd7,  32'h0);
        add(1, 0, 5'd0,  5'd0,  1, 5'd3, 5'd7,  32'hDEADBEEF, 0, 5'd3,  5'd3,   0, 5'd0,  32'hDEADBEEF, 0, 5'd0,  32'hDEADBEEF);
        add(1, 0, 5'd0,  5'd0,  0, 5'd0, 5'd0,  32'h0,        0, 5'd3,  5'd5,   0, 5'd0,  32'hDEADBEEF, 0, 5'd0,  32'h0);
        add(1, 1, 5'd4,  5'd2,  0, 5'd0, 5'd0,  32'h0,        0, 5'd4,  5'd4,   0, 5'd0,  32'h0,        0, 5'd0,  32'h0);
        add(1, 1, 5'd4,  5'd9,  0, 5'd0, 5'd0,  32'h0,        0, 5'd4,  5'd4,   1, 5'd2,  32'h0,        1, 5'd2,  32'h0);
        add(1, 0, 5'd0,  5'd0,  1, 5'd4, 5'd2,  32'h11,       0, 5'd4,  5'd4,   1, 5'd9,  32'h0,        1, 5'd9,  32'h0);
        add(1, 0, 5'd0,  5'd0,  1, 5'd4, 5'd9,  32'h22,       0, 5'd4,  5'd4,   0, 5'd0,  32'h22,       0, 5'd0,  32'h22);
        add(1, 0, 5'd0,  5'd0,  0, 5'd0, 5'd0,  32'h0,        0, 5'd4,  5'd3,   0, 5'd0,  32'h22,       0, 5'd0,  32'hDEADBEEF);
        add(1, 1, 5'd6,  5'd5,  0, 5'd0, 5'd0,  32'h0,        0, 5'd6,  5'd6,   0, 5'd0,  32'h0,        0, 5'd0,  32'h0);
        add(1, 1, 5'd6,  5'd12, 1, 5'd6, 5'd5,  32'h55,       0, 5'd6,  5'd6,   0, 5'd0,  32'h55,       0, 5'd0,  32'h55);
        add(1, 0, 5'd0,  5'd0,  0, 5'd0, 5'd0,  32'h0,        0, 5'd6,  5'd3,   1, 5'd12, 32'h55,       0, 5'd0,  32'hDEADBEEF);
        add(1, 1, 5'd1,  5'd1,  0, 5'd0, 5'd0,  32'h0,        0, 5'd2,  5'd1,   0, 5'd0,  32'h0,        0, 5'd0,  32'h0);
        add(1, 1, 5'd2,  5'd2,  0, 5'd0, 5'd0,  32'h0,        0, 5'd1,  5'd2,   1, 5'd1,  32'h0,        0, 5'd0,  32'h0);
        add(1, 1, 5'd10, 5'd10, 0, 5'd0, 5'd0,  32'h0,        0, 5'd2,  5'd1,   1, 5'd2,  32'h0,        1, 5'd1,  32'h0);
        add(1, 1, 5'd8,  5'd3,  0, 5'd0, 5'd0,  32'h0,        1, 5'd10, 5'd8,   1, 5'd10, 32'h0,        0, 5'd0,  32'h0);
        add(1, 0, 5'd0,  5'd0,  0, 5'd0, 5'd0,  32'h0,        0, 5'd10, 5'd8,   0, 5'd0,  32'h0,        0, 5'd0,  32'h0);
        add(1, 0, 5'd0,  5'd0,  0, 5'd0, 5'd0,  32'h0,        0, 5'd1,  5'd6,   0, 5'd0,  32'h0,        0, 5'd0,  32'h55);
        add(1, 1, 5'd0,  5'd1,  1, 5'd0, 5'd0,  32'hFF,       0, 5'd0,  5'd0,   0, 5'd0,  32'h0,        0, 5'd0,  32'h0);
        add(1, 0, 5'd0,  5'd0,  0, 5'd0, 5'd0,  32'h0,        0, 5'd0,  5'd2,   0, 5'd0,  32'h0,        0, 5'd0,  32'h0);
        add(0, 1, 5'd5,  5'd4,  0, 5'd0, 5'd0,  32'h0,        0, 5'd5,  5'd5,   0, 5'd0,  32'h0,        0, 5'd0,  32'h0);
        add(1, 0, 5'd0,  5'd0,  0, 5'd0, 5'd0,  32'h0,        0, 5'd5,  5'd5,   0, 5'd0,  32'h0,        0, 5'd0,  32'h0);
        add(1, 1, 5'd5,  5'd4,  0, 5'd0, 5'd0,  32'h0,        0, 5'd5,  5'd5,   0, 5'd0,  32'h0,        0, 5'd0,  32'h0);
        add(0, 0, 5'd0,  5'd0,  1, 5'd5, 5'd4,  32'h77,       0, 5'd5,  5'd5,   1, 5'd4,  32'h0,        1, 5'd4,  32'h0);
        add(1, 0, 5'd0,  5'd0,  0, 5'd0, 5'd0,  32'h0,        0, 5'd5,  5'd5,   1, 5'd4,  32'h0,        1, 5'd4,  32'h0);
        add(1, 0, 5'd0,  5'd0,  1, 5'd5, 5'd4,  32'h77,       0, 5'd5,  5'd5,   0, 5'd0,  32'h77,       0, 5'd0,  32'h77);
        add(1, 0, 5'd0,  5'd0,  0, 5'd0, 5'd0,  32'h0,        0, 5'd5,  5'd4,   0, 5'd0,  32'h77,       0, 5'd0,  32'h22);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rdy, vecs[i].iv, vecs[i].ird, vecs[i].iq, vecs[i].cv, vecs[i].crd,
                  vecs[i].cq, vecs[i].cval, vecs[i].fl, vecs[i].a1, vecs[i].a2);
            @(negedge clk_in);
            chk_ports($sformatf("vec%0d", i), vecs[i].eb1, vecs[i].eq1, vecs[i].ev1,
                      vecs[i].eb2, vecs[i].eq2, vecs[i].ev2);
            @(posedge clk_in);
            m_clock();
            #1;
        end

        random_cycles(400);

        // Asynchronous reset between clock edges while traffic is active.
        drive(1'b1, 1'b1, 5'd7, 5'd9, 1'b1, 5'd3, 5'd1, 32'h1234_5678, 1'b1, 5'd3, 5'd7);
        @(negedge clk_in);
        #2;
        rst_in = 1'b1;
        #1;
        chk_ports("async_rst", 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        @(posedge clk_in);
        #1;
        chk_ports("rst_held", 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        @(negedge clk_in);
        drive(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0, 32'h0, 1'b0, 5'd3, 5'd4);
        rst_in = 1'b0;
        m_clear(1'b1);
        #1;
        chk_ports("post_rst", 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        @(posedge clk_in);
        #1;

        random_cycles(100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_regfile

`default_nettype wire
